// File: rtl/adder16_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial adder controller.
// Holds the FSM state encoding and the adder slice width.
package adder16_seq_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fullAdder_4bits.sv
// 4-bit ripple full adder slice, purely combinational.
// Ports: a, b (4b), c_in -> sum (4b), c_out.
module fullAdder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/adder16_seq_ctrl.sv
// Nibble-serial adder: {c_out,sum} = a + b + c_in over NIBBLES clocks.
// Ports: clk, rst_n (sync, low), start, a, b, c_in -> ready, busy, done, sum, c_out.
module adder16_seq_ctrl
  import adder16_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          c_in,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          c_out
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [NIBBLE_W-1:0] add_a;
  logic [NIBBLE_W-1:0] add_b;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_co;

  assign add_a = a_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];
  assign add_b = b_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];

  fullAdder_4bits u_add (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADD;
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      ST_ADD: begin
        sum_d[int'(cnt_q)*NIBBLE_W +: NIBBLE_W] = add_sum;
        carry_d = add_co;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = add_co;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_ADD);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_adder16_seq_ctrl.sv
// Bench for adder16_seq_ctrl: directed cases plus random traffic
// against a cycle-count model of accept -> N busy cycles -> done.
module tb_adder16_seq_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        c_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, busy, done, c_out;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: phase 0 idle, 1..N busy, N+1 done
  int          phase = 0;
  bit          model_ok = 0;
  logic [16:0] pend = '0;
  logic [16:0] m_res = '0;

  always #5 clk = ~clk;

  adder16_seq_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      phase = 0;
      m_res = '0;
      model_ok = 1;
    end else if (phase == 0) begin
      if (start) begin
        phase = 1;
        pend = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
      end
    end else if (phase <= N) begin
      phase++;
      if (phase == N + 1) m_res = pend;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("ready", 32'(ready), 32'(phase == 0));
      chk("busy", 32'(busy), 32'(phase >= 1 && phase <= N));
      chk("done", 32'(done), 32'(phase == N + 1));
      if (phase == 0 || phase == N + 1) begin
        chk("sum", 32'(sum), 32'(m_res[15:0]));
        chk("c_out", 32'(c_out), 32'(m_res[16]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input bit zero_after,
                        input logic [15:0] es, input logic ec);
    int lat;
    a = ia;
    b = ib;
    c_in = ic;
    start = 1'b1;
    step();
    start = 1'b0;
    if (zero_after) begin
      a = '0;
      b = '0;
      c_in = 1'b0;
    end
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(c_out), 32'(ec));
    chk("model_sum", 32'(m_res[15:0]), 32'(es));
    chk("model_cout", 32'(m_res[16]), 32'(ec));
    step();
    chk("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    int lat;
    int dn;
    int t[$];
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);

    run_op(16'h0034, 16'h0045, 1'b0, 0, 16'h0079, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1);
    run_op(16'h1234, 16'h5678, 1'b1, 1, 16'h68AD, 1'b0);

    // start re-pulsed in ADD and in DONE
    a = 16'h0100;
    b = 16'h0200;
    c_in = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    chk("ign_sum", 32'(sum), 32'h0300);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_ready", 32'(ready), 32'd1);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dn++;
    end
    chk("ign_extra_done", 32'(dn), 32'd0);

    // reset during third ADD cycle
    a = 16'h7777;
    b = 16'h9999;
    c_in = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run_op(16'h9A5F, 16'h0A0A, 1'b0, 0, 16'hA469, 1'b0);

    // start held high: back-to-back every 6 cycles
    a = 16'h8000;
    b = 16'h8000;
    c_in = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) begin
        t.push_back(cyc);
        chk("b2b_sum", 32'(sum), 32'h0000);
        chk("b2b_cout", 32'(c_out), 32'd1);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(t.size() >= 4), 32'd1);
    for (int k = 0; k + 1 < t.size(); k++)
      chk("b2b_period", 32'(t[k+1] - t[k]), 32'd6);
    for (int i = 0; i < 8; i++) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      start = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = 16'($urandom);
      c_in = 1'($urandom_range(0, 1));
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
